// File: rtl/cs_to_bin_reduce.sv
// Carry-save (s0, s1) to binary conversion with final conditional subtraction of n.
// Works W bits per cycle with registered carry/borrow so no K-bit carry chain exists.
module cs_to_bin_reduce #(
  parameter int K = 2 + 1024 + 1,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic         start,
  input  logic [K-1:0] s0,
  input  logic [K-1:0] s1,
  input  logic [K-1:0] n,
  output logic         ready,
  output logic         done,
  output logic [K-1:0] result
);

  // state | meaning
  // IDLE  | waiting for start
  // ADD   | one W-bit chunk of sum and sum-n per ce cycle
  // DONE  | result valid for one cycle, back-to-back start accepted
  localparam int C  = (K + W - 1) / W;
  localparam int P  = C * W;
  localparam int IW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t         state, state_nx;
  logic [IW-1:0]  idx;
  logic           cy, bw;
  logic [P-1:0]   s0_r, s1_r, n_r, sum_r, diff_r;
  logic [P-1:0]   sum_nx, diff_nx;
  logic [W-1:0]   sc, dc;
  logic           cy_nx, bw_nx, last, accept, ge;

  assign last   = (idx == IW'(C - 1));
  assign accept = ce & ~clr & start & (state != ADD);

  assign {cy_nx, sc} = {1'b0, s0_r[W-1:0]} + {1'b0, s1_r[W-1:0]} + {{W{1'b0}}, cy};
  assign {bw_nx, dc} = {1'b0, sc} - {1'b0, n_r[W-1:0]} - {{W{1'b0}}, bw};

  // Chunks enter at the top so after C shifts chunk 0 sits at bit 0.
  assign sum_nx  = (sum_r  >> W) | (P'(sc) << (P - W));
  assign diff_nx = (diff_r >> W) | (P'(dc) << (P - W));

  // A carry out of the padded sum already exceeds any K-bit n.
  assign ge = cy_nx | ~bw_nx;

  always_ff @(posedge clk) begin
    if (rst)     state <= IDLE;
    else if (ce) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nx = ADD;
        ADD:     if (last)  state_nx = DONE;
        DONE:    state_nx = start ? ADD : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (state != ADD);
    done  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      cy     <= 1'b0;
      bw     <= 1'b0;
      s0_r   <= '0;
      s1_r   <= '0;
      n_r    <= '0;
      sum_r  <= '0;
      diff_r <= '0;
      result <= '0;
    end else if (ce & ~clr) begin
      if (accept) begin
        s0_r <= P'(s0);
        s1_r <= P'(s1);
        n_r  <= P'(n);
        idx  <= '0;
        cy   <= 1'b0;
        bw   <= 1'b0;
      end else if (state == ADD) begin
        s0_r   <= s0_r >> W;
        s1_r   <= s1_r >> W;
        n_r    <= n_r >> W;
        cy     <= cy_nx;
        bw     <= bw_nx;
        idx    <= idx + IW'(1);
        sum_r  <= sum_nx;
        diff_r <= diff_nx;
        if (last) result <= ge ? diff_nx[K-1:0] : sum_nx[K-1:0];
      end
    end
  end

endmodule

// File: tb/tb_cs_to_bin_reduce.sv
// Scoreboard bench: a narrow padded instance (K=8, W=3) for directed cases and
// a default-width instance for random back-to-back vectors.
module tb_cs_to_bin_reduce;

  localparam int KA = 8;
  localparam int WA = 3;
  localparam int CA = (KA + WA - 1) / WA;
  localparam int KB = 1027;
  localparam int N_RAND = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ce, clr, start_a, start_b;
  logic [KA-1:0] s0_a, s1_a, n_a, result_a;
  logic [KB-1:0] s0_b, s1_b, n_b, result_b;
  logic ready_a, done_a, ready_b, done_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [KA-1:0] q_a[$];
  logic [KB-1:0] q_b[$];
  logic ce_last = 1'b1, done_a_prev = 1'b0, done_b_prev = 1'b0;
  logic [KA-1:0] va [4][3];

  cs_to_bin_reduce #(.K(KA), .W(WA)) u_dut_a (
    .clk(clk), .rst(rst), .ce(ce), .clr(clr), .start(start_a),
    .s0(s0_a), .s1(s1_a), .n(n_a),
    .ready(ready_a), .done(done_a), .result(result_a)
  );

  cs_to_bin_reduce u_dut_b (
    .clk(clk), .rst(rst), .ce(ce), .clr(clr), .start(start_b),
    .s0(s0_b), .s1(s1_b), .n(n_b),
    .ready(ready_b), .done(done_b), .result(result_b)
  );

  task automatic chk(input string tag, input logic [KB-1:0] obs, input logic [KB-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KA-1:0] ref_a(input logic [KA-1:0] a, input logic [KA-1:0] b,
                                          input logic [KA-1:0] m);
    logic [KA:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[KA-1:0];
  endfunction

  function automatic logic [KB-1:0] ref_b(input logic [KB-1:0] a, input logic [KB-1:0] b,
                                          input logic [KB-1:0] m);
    logic [KB:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[KB-1:0];
  endfunction

  function automatic logic [KB-1:0] rnd_b();
    logic [33*32-1:0] t;
    for (int j = 0; j < 33; j++) t[j*32 +: 32] = $urandom;
    return t[KB-1:0];
  endfunction

  // A done seen again after a ce=0 edge is the same stalled pulse, not a new one.
  always @(posedge clk) ce_last <= ce;

  always @(negedge clk) begin
    if (done_a && !(done_a_prev && !ce_last)) begin
      if (q_a.size() == 0) chk("unexpected_done_a", KB'(done_a), '0);
      else                 chk("result_a", KB'(result_a), KB'(q_a.pop_front()));
    end
    if (done_b && !(done_b_prev && !ce_last)) begin
      if (q_b.size() == 0) chk("unexpected_done_b", KB'(done_b), '0);
      else                 chk("result_b", result_b, q_b.pop_front());
    end
    done_a_prev <= done_a;
    done_b_prev <= done_b;
  end

  task automatic go_a(input logic [KA-1:0] a, input logic [KA-1:0] b, input logic [KA-1:0] m,
                      input bit expect_done);
    @(negedge clk);
    s0_a = a; s1_a = b; n_a = m; start_a = 1'b1;
    if (expect_done) q_a.push_back(ref_a(a, b, m));
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Called on the first negedge after the accepting edge (counted as cycle 1).
  task automatic wait_done_a(output int cyc);
    cyc = 1;
    while (!done_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, stall_at, k, guard, mode;
    logic [KB-1:0] a, b, m;
    logic [KB:0] sm;

    rst = 1'b1; ce = 1'b1; clr = 1'b0; start_a = 1'b0; start_b = 1'b0;
    s0_a = '0; s1_a = '0; n_a = '0; s0_b = '0; s1_b = '0; n_b = '0;
    va = '{'{8'd150, 8'd100, 8'd200}, '{8'd100, 8'd50, 8'd200},
           '{8'd120, 8'd80, 8'd200},  '{8'd255, 8'd200, 8'd255}};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", KB'(ready_a), KB'(1));
    chk("rst_done", KB'(done_a), '0);
    chk("rst_result", KB'(result_a), '0);

    for (int i = 0; i < 4; i++) begin
      go_a(va[i][0], va[i][1], va[i][2], 1'b1);
      wait_done_a(cyc);
      chk("latency_a", KB'(cyc), KB'(CA + 1));
      @(negedge clk);
    end

    // Reset during ADD: conversion discarded, result cleared.
    go_a(8'd150, 8'd100, 8'd200, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", KB'(ready_a), KB'(1));
    chk("midrst_done", KB'(done_a), '0);
    chk("midrst_result", KB'(result_a), '0);
    repeat (10) @(negedge clk);

    // Back-to-back: start held through ADD, new operands accepted only in DONE.
    s0_a = 8'd150; s1_a = 8'd100; n_a = 8'd200; start_a = 1'b1;
    q_a.push_back(ref_a(8'd150, 8'd100, 8'd200));
    @(negedge clk);
    s0_a = 8'd10; s1_a = 8'd20;
    q_a.push_back(ref_a(8'd10, 8'd20, 8'd200));
    wait_done_a(cyc);
    chk("b2b_first_latency", KB'(cyc), KB'(CA + 1));
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(cyc);
    chk("b2b_second_latency", KB'(cyc), KB'(CA + 1));
    @(negedge clk);

    // ce low for 5 cycles mid-ADD delays done by exactly 5.
    go_a(8'd150, 8'd100, 8'd200, 1'b1);
    stall_at = $urandom_range(1, CA - 1);
    cyc = 1;
    while (!done_a && cyc < 100) begin
      if (cyc == stall_at) begin
        ce = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        cyc += 5;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("ce_stall_latency", KB'(cyc), KB'(CA + 1 + 5));
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", KB'(done_a), KB'(1));
    end
    ce = 1'b1;
    @(negedge clk);
    chk("done_drop", KB'(done_a), '0);

    // clr mid-ADD: back to IDLE, no done, result keeps 50.
    go_a(8'd10, 8'd20, 8'd200, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_ready", KB'(ready_a), KB'(1));
    repeat (8) @(negedge clk);
    chk("clr_done", KB'(done_a), '0);
    chk("clr_result", KB'(result_a), KB'(8'd50));

    // clr wins over a simultaneous start.
    s0_a = 8'd1; s1_a = 8'd2; n_a = 8'd200; start_a = 1'b1; clr = 1'b1;
    @(negedge clk);
    start_a = 1'b0; clr = 1'b0;
    chk("clr_start_ready", KB'(ready_a), KB'(1));
    repeat (6) @(negedge clk);

    // Random back-to-back vectors at full width.
    k = 0;
    guard = 0;
    while (k < N_RAND && guard < 80000) begin
      @(negedge clk);
      guard++;
      if (ready_b && $urandom_range(0, 7) != 0) begin
        mode = $urandom_range(0, 4);
        a = rnd_b(); b = rnd_b(); m = rnd_b();
        if (mode != 0 && mode != 4) begin
          a[KB-1] = 1'b0; b[KB-1] = 1'b0;
        end
        sm = {1'b0, a} + {1'b0, b};
        case (mode)
          0: m[KB-1] = 1'b1;
          1: m = KB'((sm >> 1) + 1);
          2: m = sm[KB-1:0];
          3: m = KB'(sm + 1);
          default: begin a = '1; b = '1; m = '1; end
        endcase
        s0_b = a; s1_b = b; n_b = m; start_b = 1'b1;
        q_b.push_back(ref_b(a, b, m));
        k++;
      end else begin
        start_b = ready_b ? 1'b0 : 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    start_b = 1'b0;
    chk("rand_issued", KB'(k), KB'(N_RAND));
    guard = 0;
    while (q_b.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_b", KB'(q_b.size()), '0);
    chk("drain_a", KB'(q_a.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
